// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg : parity encodings and the TX/RX state set for uart_core    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_bit_timer : loadable bit-period counter with terminal pulse     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (en) begin
            r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign tc = en && !load && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_core : full-duplex UART transmitter and receiver                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_pin,
    output logic       tx_busy,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int               CNT_W       = $clog2(CLKS_PER_BIT);
    localparam logic [2:0]       c_LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] c_HALF_LOAD = CNT_W'(CLKS_PER_BIT - CLKS_PER_BIT / 2);
    localparam logic [7:0]       c_DATA_MASK = 8'(8'hFF >> (8 - DATA_BITS));
    localparam logic             c_ODD       = (PARITY == PARITY_ODD);
    localparam logic             c_HAS_PAR   = (PARITY == PARITY_ODD) || (PARITY == PARITY_EVEN);
    localparam logic             c_TWO_STOP  = (STOP_BITS == 2);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
            $error("uart_core: DATA_BITS must be 5..8");
        end
        if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_bad_parity
            $error("uart_core: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_core: STOP_BITS must be 1 or 2");
        end
        if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
            $error("uart_core: CLKS_PER_BIT must be >= 4");
        end
    endgenerate

    // ------------------------------------------------------------ transmit
    uart_state_t r_tx_state, w_tx_next;
    logic        r_tx_pin, w_tx_pin_next, r_tx_busy;
    logic [7:0]  r_tx_shift;
    logic        r_tx_par;
    logic [2:0]  r_tx_idx;
    logic        w_tx_load, w_tx_tc;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT), .CNT_W(CNT_W)) u_tx_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_tx_load),
        .load_val ('0),
        .en       (r_tx_state != ST_IDLE),
        .tc       (w_tx_tc)
    );

    // Pin value is registered alongside the state so the line never glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= ST_IDLE;
            r_tx_pin   <= 1'b1;
            r_tx_busy  <= 1'b0;
        end else begin
            r_tx_state <= w_tx_next;
            r_tx_pin   <= w_tx_pin_next;
            r_tx_busy  <= (w_tx_next != ST_IDLE);
        end
    end

    always_comb begin
        w_tx_next     = r_tx_state;
        w_tx_pin_next = r_tx_pin;
        w_tx_load     = 1'b0;
        case (r_tx_state)
            ST_IDLE: begin
                w_tx_pin_next = 1'b1;
                if (tx_start) begin
                    w_tx_next     = ST_START;
                    w_tx_pin_next = 1'b0;
                    w_tx_load     = 1'b1;
                end
            end
            ST_START: if (w_tx_tc) begin
                w_tx_next     = ST_DATA;
                w_tx_pin_next = r_tx_shift[0];
            end
            ST_DATA: if (w_tx_tc) begin
                if (r_tx_idx == c_LAST_DATA) begin
                    w_tx_next     = c_HAS_PAR ? ST_PARITY : ST_STOP;
                    w_tx_pin_next = c_HAS_PAR ? r_tx_par : 1'b1;
                end else begin
                    w_tx_pin_next = r_tx_shift[1];
                end
            end
            ST_PARITY: if (w_tx_tc) begin
                w_tx_next     = ST_STOP;
                w_tx_pin_next = 1'b1;
            end
            ST_STOP: if (w_tx_tc) begin
                w_tx_pin_next = 1'b1;
                if (!(c_TWO_STOP && r_tx_idx == 3'd0)) begin
                    w_tx_next = ST_IDLE;
                end
            end
            default: begin
                w_tx_next     = ST_IDLE;
                w_tx_pin_next = 1'b1;
            end
        endcase
    end

    // Bit index restarts on every state change; it also counts stop bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx_idx   <= '0;
        end else begin
            if (w_tx_load) begin
                r_tx_shift <= tx_data & c_DATA_MASK;
                r_tx_par   <= ^(tx_data & c_DATA_MASK) ^ c_ODD;
            end else if (w_tx_tc && r_tx_state == ST_DATA) begin
                r_tx_shift <= r_tx_shift >> 1;
            end
            if (w_tx_next != r_tx_state) begin
                r_tx_idx <= '0;
            end else if (w_tx_tc) begin
                r_tx_idx <= r_tx_idx + 1'b1;
            end
        end
    end

    assign tx_pin  = r_tx_pin;
    assign tx_busy = r_tx_busy;

    // ------------------------------------------------------------- receive
    logic        r_sync1, r_sync2, r_rx_prev;
    logic        w_rx, w_rx_fall;
    uart_state_t r_rx_state, w_rx_next;
    logic        w_rx_load, w_rx_tc, w_rx_done, w_rx_par_exp;
    logic [7:0]  r_rx_shift, r_rx_data;
    logic        r_rx_par_bit;
    logic [2:0]  r_rx_idx;
    logic        r_rx_valid, r_rx_perr, r_rx_ferr, r_rx_busy;

    assign w_rx         = r_sync2;
    assign w_rx_fall    = r_rx_prev && !r_sync2;
    assign w_rx_par_exp = ^r_rx_shift ^ c_ODD;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx_pin;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    // Loading the half-period offset puts every later sample mid-bit.
    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT), .CNT_W(CNT_W)) u_rx_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_rx_load),
        .load_val (c_HALF_LOAD),
        .en       (r_rx_state != ST_IDLE),
        .tc       (w_rx_tc)
    );

    always_comb begin
        w_rx_next = r_rx_state;
        w_rx_load = 1'b0;
        w_rx_done = 1'b0;
        case (r_rx_state)
            ST_IDLE: if (w_rx_fall) begin
                w_rx_next = ST_START;
                w_rx_load = 1'b1;
            end
            ST_START: if (w_rx_tc) begin
                w_rx_next = w_rx ? ST_IDLE : ST_DATA;
            end
            ST_DATA: if (w_rx_tc && r_rx_idx == c_LAST_DATA) begin
                w_rx_next = c_HAS_PAR ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: if (w_rx_tc) begin
                w_rx_next = ST_STOP;
            end
            ST_STOP: if (w_rx_tc) begin
                w_rx_next = ST_IDLE;
                w_rx_done = 1'b1;
            end
            default: w_rx_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_state <= ST_IDLE;
            r_rx_busy  <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_perr  <= 1'b0;
            r_rx_ferr  <= 1'b0;
            r_rx_data  <= '0;
        end else begin
            r_rx_state <= w_rx_next;
            r_rx_busy  <= (w_rx_next != ST_IDLE);
            r_rx_valid <= w_rx_done;
            r_rx_perr  <= w_rx_done && c_HAS_PAR && (r_rx_par_bit != w_rx_par_exp);
            r_rx_ferr  <= w_rx_done && !w_rx;
            if (w_rx_done) begin
                r_rx_data <= r_rx_shift;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_shift   <= '0;
            r_rx_par_bit <= 1'b0;
            r_rx_idx     <= '0;
        end else begin
            if (w_rx_load) begin
                r_rx_shift <= '0;
            end else if (w_rx_tc && r_rx_state == ST_DATA) begin
                r_rx_shift[r_rx_idx] <= w_rx;
            end
            if (w_rx_tc && r_rx_state == ST_PARITY) begin
                r_rx_par_bit <= w_rx;
            end
            if (w_rx_next != r_rx_state) begin
                r_rx_idx <= '0;
            end else if (w_rx_tc) begin
                r_rx_idx <= r_rx_idx + 1'b1;
            end
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign rx_busy    = r_rx_busy;
    assign parity_err = r_rx_perr;
    assign frame_err  = r_rx_ferr;

endmodule
`default_nettype wire

// File: tb/tb_uart_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_core : directed bench for an 8N1 and an 8E1 uart_core        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_uart_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       tx_start_n, tx_start_e;
    logic [7:0] tx_data_n, tx_data_e;
    logic       tx_pin_n, tx_busy_n, tx_pin_e, tx_busy_e;
    logic       rx_n, rx_e_drv, loop_e;
    wire        rx_pin_e = loop_e ? tx_pin_e : rx_e_drv;
    logic [7:0] rx_data_n, rx_data_e;
    logic       rx_valid_n, rx_valid_e, rx_busy_n, rx_busy_e;
    logic       perr_n, perr_e, ferr_n, ferr_e;

    uart_core #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(4)) dut_n (
        .clk(clk), .reset(reset),
        .tx_start(tx_start_n), .tx_data(tx_data_n), .tx_pin(tx_pin_n), .tx_busy(tx_busy_n),
        .rx_pin(rx_n), .rx_data(rx_data_n), .rx_valid(rx_valid_n), .rx_busy(rx_busy_n),
        .parity_err(perr_n), .frame_err(ferr_n)
    );

    uart_core #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(4)) dut_e (
        .clk(clk), .reset(reset),
        .tx_start(tx_start_e), .tx_data(tx_data_e), .tx_pin(tx_pin_e), .tx_busy(tx_busy_e),
        .rx_pin(rx_pin_e), .rx_data(rx_data_e), .rx_valid(rx_valid_e), .rx_busy(rx_busy_e),
        .parity_err(perr_e), .frame_err(ferr_e)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Receive monitor: records each strobe and flags error bits outside it.
    int         n_val_n = 0, n_val_e = 0;
    logic [7:0] cap_data_n = '0, cap_data_e = '0;
    logic       cap_perr_n = 0, cap_ferr_n = 0, cap_perr_e = 0, cap_ferr_e = 0;
    logic       stray_err = 0;

    always @(negedge clk) begin
        if (rx_valid_n) begin
            n_val_n++;
            cap_data_n = rx_data_n;
            cap_perr_n = perr_n;
            cap_ferr_n = ferr_n;
        end else if (perr_n || ferr_n) begin
            stray_err = 1'b1;
        end
        if (rx_valid_e) begin
            n_val_e++;
            cap_data_e = rx_data_e;
            cap_perr_e = perr_e;
            cap_ferr_e = ferr_e;
        end else if (perr_e || ferr_e) begin
            stray_err = 1'b1;
        end
    end

    task automatic drive_frame(input bit to_e, input logic [11:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (to_e) rx_e_drv = bits[i];
            else      rx_n     = bits[i];
            tick(4);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [9:0] frame;
    int         busy_cnt, base, guard;
    logic       par_seen;

    initial begin
        reset = 1'b1; tx_start_n = 0; tx_start_e = 0; tx_data_n = '0; tx_data_e = '0;
        rx_n = 1'b1; rx_e_drv = 1'b1; loop_e = 1'b0;
        tick(3);
        check("rst_tx_pin", tx_pin_n, 1);
        check("rst_tx_busy", tx_busy_n, 0);
        check("rst_rx_busy", rx_busy_n, 0);
        check("rst_rx_valid", rx_valid_n, 0);
        check("rst_rx_data", rx_data_n, 8'h00);
        check("rst_errs", {perr_n, ferr_n}, 0);
        check("rst_tx_pin_e", tx_pin_e, 1);
        reset = 1'b0;
        tick(2);

        // 8N1 0xA5 waveform, with an ignored tx_start during the frame
        frame = 10'b1101001010;
        busy_cnt = 0;
        tx_data_n = 8'hA5; tx_start_n = 1'b1;
        tick();
        tx_start_n = 1'b0;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 4; c++) begin
                check($sformatf("a5_bit%0d_c%0d", b, c), tx_pin_n, frame[b]);
                if (tx_busy_n) busy_cnt++;
                if (b == 3 && c == 1) begin tx_start_n = 1'b1; tx_data_n = 8'h00; end
                if (b == 3 && c == 2) tx_start_n = 1'b0;
                tick();
            end
        end
        check("a5_busy_len", busy_cnt, 40);
        check("a5_end_busy", tx_busy_n, 0);
        check("a5_end_pin", tx_pin_n, 1);
        busy_cnt = 0;
        repeat (8) begin
            if (tx_busy_n) busy_cnt++;
            tick();
        end
        check("no_queue", busy_cnt, 0);

        // back-to-back frames
        tx_data_n = 8'h00; tx_start_n = 1'b1;
        tick();
        tx_start_n = 1'b0;
        busy_cnt = 0; guard = 0;
        while (tx_busy_n && guard < 100) begin
            busy_cnt++; guard++;
            tick();
        end
        check("b2b_len", busy_cnt, 40);
        tx_data_n = 8'hFF; tx_start_n = 1'b1;
        tick();
        tx_start_n = 1'b0;
        check("b2b_busy", tx_busy_n, 1);
        check("b2b_start_bit", tx_pin_n, 0);
        tick(44);
        check("b2b_done", tx_busy_n, 0);

        // 8E1 loopback of 0x07
        loop_e = 1'b1;
        base = n_val_e;
        tx_data_e = 8'h07; tx_start_e = 1'b1;
        tick();
        tx_start_e = 1'b0;
        busy_cnt = 0; par_seen = 1'bx;
        for (int i = 0; i < 44; i++) begin
            if (tx_busy_e) busy_cnt++;
            if (i == 37) par_seen = tx_pin_e;
            tick();
        end
        check("e_busy_len", busy_cnt, 44);
        check("e_parity_bit", par_seen, 1);
        guard = 0;
        while (n_val_e == base && guard < 40) begin guard++; tick(); end
        tick(4);
        check("lb_count", n_val_e - base, 1);
        check("lb_data", cap_data_e, 8'h07);
        check("lb_perr", cap_perr_e, 0);
        check("lb_ferr", cap_ferr_e, 0);
        loop_e = 1'b0;
        tick(4);

        // 8E1 receive of 0x07 with a wrong parity bit
        base = n_val_e;
        drive_frame(1'b1, 12'b100_0000_1110, 11);
        tick(10);
        check("perr_count", n_val_e - base, 1);
        check("perr_data", cap_data_e, 8'h07);
        check("perr_flag", cap_perr_e, 1);
        check("perr_ferr", cap_ferr_e, 0);

        // 8N1 receive of 0x3C with the stop bit low
        base = n_val_n;
        drive_frame(1'b0, 12'b00_0111_1000, 10);
        rx_n = 1'b1;
        tick(10);
        check("ferr_count", n_val_n - base, 1);
        check("ferr_data", cap_data_n, 8'h3C);
        check("ferr_flag", cap_ferr_n, 1);
        check("ferr_perr", cap_perr_n, 0);
        check("rx_data_hold", rx_data_n, 8'h3C);

        // one-cycle low glitch on the receive line
        base = n_val_n;
        rx_n = 1'b0;
        tick();
        rx_n = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (rx_busy_n) busy_cnt++;
            tick();
        end
        check("glitch_busy_cycles", busy_cnt, 2);
        check("glitch_no_valid", n_val_n - base, 0);
        check("glitch_idle", rx_busy_n, 0);

        // reset in the middle of a received frame
        base = n_val_n;
        drive_frame(1'b0, 12'b1010, 4);
        check("rxmid_busy", rx_busy_n, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rxmid_rst_busy", rx_busy_n, 0);
        rx_n = 1'b1;
        tick(50);
        check("rxmid_no_valid", n_val_n - base, 0);

        // reset during TX data bit 3, after an ignored tx_start
        tx_data_n = 8'h5A; tx_start_n = 1'b1;
        tick();
        tx_start_n = 1'b0;
        tick(6);
        tx_start_n = 1'b1;
        tick();
        tx_start_n = 1'b0;
        tick(10);
        check("txmid_busy", tx_busy_n, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("txrst_pin", tx_pin_n, 1);
        check("txrst_busy", tx_busy_n, 0);
        busy_cnt = 0;
        repeat (50) begin
            if (tx_busy_n || !tx_pin_n) busy_cnt++;
            tick();
        end
        check("txrst_no_frame", busy_cnt, 0);

        check("no_stray_err", stray_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame, legal 5..8.
REQ-002 SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-003 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame, legal 1 or 2.
REQ-004 SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per bit period, legal >=4.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports tx_start in 1 (frame request), tx_data in 8 (payload, bits above DATA_BITS ignored), tx_pin out 1 (serial out), tx_busy out 1 (frame in progress).
REQ-008 SHALL have ports rx_pin in 1 (asynchronous serial in), rx_data out 8 (payload, bits above DATA_BITS zero), rx_valid out 1 (one-cycle strobe), rx_busy out 1 (frame in progress), parity_err out 1, frame_err out 1.

Function
REQ-009 Frame SHALL be start (0), DATA_BITS data LSB first, optional parity, STOP_BITS stop (1); each bit held exactly CLKS_PER_BIT cycles.
REQ-010 TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY skipped when PARITY=0.
REQ-011 tx_start sampled high in IDLE SHALL latch tx_data; tx_busy and start bit (tx_pin=0) appear the next cycle.
REQ-012 tx_start while tx_busy=1 SHALL be ignored; no queuing.
REQ-013 tx_busy SHALL stay high for exactly (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles, then drop; tx_start in the first idle cycle SHALL start the next frame (back-to-back, no extra idle bit).
REQ-014 Parity bit SHALL be XOR of data bits for even, its inverse for odd.
REQ-015 tx_pin SHALL be 1 whenever TX is IDLE; no glitch at STOP->IDLE.
REQ-016 rx_pin SHALL pass a 2-flop synchroniser before use; all RX timing below is relative to the synchronised signal.
REQ-017 RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP; falling edge in IDLE enters START and sets rx_busy.
REQ-018 RX SHALL re-sample at CLKS_PER_BIT/2 into START; if high, return to IDLE without rx_valid (glitch reject).
REQ-019 Data, parity, first stop bit SHALL each be sampled once, CLKS_PER_BIT cycles after previous sample.
REQ-020 At first-stop-bit sample RX SHALL pulse rx_valid one cycle, update rx_data, set parity_err (mismatch, only when PARITY!=0) and frame_err (stop sampled 0) valid in that same cycle, then return to IDLE and clear rx_busy; second stop bit not checked.
REQ-021 parity_err and frame_err SHALL be 0 outside rx_valid cycles; rx_data SHALL hold until next rx_valid.
REQ-022 TX and RX SHALL operate independently and simultaneously (full duplex).

Reset
REQ-023 reset SHALL, on the next clk edge, force both FSMs to IDLE and drive tx_pin=1, tx_busy=0, rx_busy=0, rx_valid=0, parity_err=0, frame_err=0, rx_data=0, synchroniser flops=1.
REQ-024 reset mid-frame SHALL abort the frame with no partial rx_valid; reset SHALL dominate tx_start in the same cycle.

Structure
REQ-025 Package uart_pkg SHALL hold parity encoding constants (PARITY_NONE/ODD/EVEN) and the shared TX/RX state enumeration.
REQ-026 Sub-module uart_bit_timer (count to CLKS_PER_BIT with load value, terminal-count pulse) SHALL be instantiated once for TX, once for RX; counter width $clog2(CLKS_PER_BIT).
REQ-027 Illegal parameter values SHALL be flagged by elaboration-time assertion.

Verification (CLKS_PER_BIT=4)
REQ-028 8N1, tx_start with 0xA5 -> tx_pin 0,1,0,1,0,0,1,0,1,1 each 4 cycles; tx_busy high exactly 40 cycles.
REQ-029 8E1 loopback tx_pin->rx_pin, send 0x07 -> parity bit 1; rx_valid once with rx_data=0x07, both errors 0.
REQ-030 8E1 RX, drive 0x07 with parity bit 0 -> rx_valid with parity_err=1, frame_err=0.
REQ-031 8N1 RX, drive 0x3C with stop bit 0 -> rx_valid, rx_data=0x3C, frame_err=1.
REQ-032 rx_pin low 1 cycle then high -> rx_busy drops after START check, no rx_valid.
REQ-033 reset at TX data bit 3, plus tx_start during busy -> tx_pin=1, tx_busy=0 the cycle after reset; ignored tx_start produces no frame.
